// File: rtl/pe_mac_acc.sv
// MAC column: per-lane signed multiply, adder tree, then a saturating output-stationary accumulator over a first..last window.
// Latency: a beat sampled at edge N with last set shows o_valid after edge N+3, plus one cycle per stalled cycle.
// Backpressure: i_stall freezes every stage; o_valid is forced low while stalled and results are emitted exactly once.
module pe_mac_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int COLUMN_NUM = 6,
    parameter int OUT_WIDTH  = 2*DATA_WIDTH,
    parameter int SUM_WIDTH  = OUT_WIDTH + $clog2(COLUMN_NUM),
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = $clog2(COLUMN_NUM+1)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_stall,
    input  logic                           i_valid,
    input  logic                           i_first,
    input  logic                           i_last,
    input  logic [CNT_WIDTH-1:0]           i_lane_cnt,
    input  logic [DATA_WIDTH*COLUMN_NUM-1:0] i_img_column,
    input  logic [DATA_WIDTH*COLUMN_NUM-1:0] i_wgt_column,
    output logic                           o_valid,
    output logic [ACC_WIDTH-1:0]           o_acc,
    output logic                           o_sat
);

    // Wide enough for acc+sum even when a single lane-sum exceeds the accumulator range.
    localparam int EXT_WIDTH = ((ACC_WIDTH > SUM_WIDTH) ? ACC_WIDTH : SUM_WIDTH) + 1;
    localparam logic signed [EXT_WIDTH-1:0] ACC_MAX =
        {{(EXT_WIDTH-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_WIDTH-1:0] ACC_MIN =
        {{(EXT_WIDTH-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    // S1: masked per-lane products
    logic signed [OUT_WIDTH-1:0] prod_d [COLUMN_NUM];
    logic signed [OUT_WIDTH-1:0] prod_q [COLUMN_NUM];
    logic                        v1_q, f1_q, l1_q;

    always_comb begin
        for (int i = 0; i < COLUMN_NUM; i++) begin
            prod_d[i] = '0;
            if (i_lane_cnt > CNT_WIDTH'(i)) begin
                prod_d[i] = $signed(i_img_column[i*DATA_WIDTH +: DATA_WIDTH]) *
                            $signed(i_wgt_column[i*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < COLUMN_NUM; i++) prod_q[i] <= '0;
            v1_q <= 1'b0;
            f1_q <= 1'b0;
            l1_q <= 1'b0;
        end else if (!i_stall) begin
            prod_q <= prod_d;
            v1_q   <= i_valid;
            f1_q   <= i_first;
            l1_q   <= i_last;
        end
    end

    // S2: sign-extended adder tree
    logic signed [SUM_WIDTH-1:0] sum_d, sum_q;
    logic                        v2_q, f2_q, l2_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < COLUMN_NUM; i++) begin
            sum_d = sum_d + SUM_WIDTH'(prod_q[i]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sum_q <= '0;
            v2_q  <= 1'b0;
            f2_q  <= 1'b0;
            l2_q  <= 1'b0;
        end else if (!i_stall) begin
            sum_q <= sum_d;
            v2_q  <= v1_q;
            f2_q  <= f1_q;
            l2_q  <= l1_q;
        end
    end

    // S3: accumulator FSM
    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        sat_q, sat_d;
    logic                        emit_q, emit_d;
    logic                        restart;
    logic signed [EXT_WIDTH-1:0] total;
    logic signed [EXT_WIDTH-1:0] clamped;
    logic                        hit;

    always_comb begin
        restart = (state_q == IDLE) || f2_q;
        total   = (restart ? '0 : EXT_WIDTH'(acc_q)) + EXT_WIDTH'(sum_q);
        clamped = total;
        hit     = 1'b0;
        if (total > ACC_MAX) begin
            clamped = ACC_MAX;
            hit     = 1'b1;
        end else if (total < ACC_MIN) begin
            clamped = ACC_MIN;
            hit     = 1'b1;
        end

        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        emit_d  = 1'b0;
        if (v2_q) begin
            acc_d   = clamped[ACC_WIDTH-1:0];
            sat_d   = (restart ? 1'b0 : sat_q) | hit;
            emit_d  = l2_q;
            state_d = l2_q ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            emit_q  <= 1'b0;
        end else if (!i_stall) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            emit_q  <= emit_d;
        end
    end

    // Output register: strobe consumed once, held low across stalls
    logic                 o_valid_q;
    logic [ACC_WIDTH-1:0] o_acc_q;
    logic                 o_sat_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid_q <= 1'b0;
            o_acc_q   <= '0;
            o_sat_q   <= 1'b0;
        end else begin
            o_valid_q <= emit_q & ~i_stall;
            if (emit_q && !i_stall) begin
                o_acc_q <= acc_q;
                o_sat_q <= sat_q;
            end
        end
    end

    assign o_valid = o_valid_q;
    assign o_acc   = o_acc_q;
    assign o_sat   = o_sat_q;

endmodule
